// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the unified-memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic [31:0]       conflict_cycles;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, conflict_cycles
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, conflict_cycles
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and DM accesses onto one single-port memory
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              own_dm;
    logic              we_q;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic [31:0]       conflict_cnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              if_ready;
    logic              dm_ready;
    logic              grant_if;

    assign grant_if = bus.if_req && (!bus.dm_req || starve_cnt >= 4'(STARVE_MAX));

    // grant / access / response sequencing with registered memory strobes and ready pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            own_dm     <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        own_dm     <= !grant_if;
                        we_q       <= !grant_if && bus.dm_we;
                        mem_en     <= 1'b1;
                        mem_we     <= !grant_if && bus.dm_we;
                        mem_addr   <= grant_if ? bus.if_addr : bus.dm_addr;
                        mem_wdata  <= bus.dm_wdata;
                        lat_cnt    <= 4'(MEM_LAT);
                        starve_cnt <= grant_if ? 4'd0 :
                                      (bus.if_req && starve_cnt != 4'd15) ? starve_cnt + 4'd1 : starve_cnt;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        if (!we_q && own_dm)  dm_rdata <= bus.mem_rdata;
                        if (!we_q && !own_dm) if_rdata <= bus.mem_rdata;
                        if_ready <= !own_dm;
                        dm_ready <= own_dm;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // saturating count of cycles in which both ports are requesting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) conflict_cnt <= 32'd0;
        else if (bus.if_req && bus.dm_req && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
    end

    assign bus.mem_en          = mem_en;
    assign bus.mem_we          = mem_we;
    assign bus.mem_addr        = mem_addr;
    assign bus.mem_wdata       = mem_wdata;
    assign bus.if_rdata        = if_rdata;
    assign bus.dm_rdata        = dm_rdata;
    assign bus.if_ready        = if_ready;
    assign bus.dm_ready        = dm_ready;
    assign bus.stall_if        = bus.if_req & ~if_ready;
    assign bus.stall_mem       = bus.dm_req & ~dm_ready;
    assign bus.conflict_cycles = conflict_cnt;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM).
- Serialises accesses through a grant/access/response state machine.
- Drives per-stage stall requests into the hazard logic.
- Keeps a conflict-cycle performance counter alongside the core's total/stall/flush counters.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory port
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..15)
STARVE_MAX, 4, number of consecutive IF-losing grants after which IF is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level; held until if_ready
if_addr  in  ADDR_W  fetch byte address
if_rdata  out  DATA_W  fetched word, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for IF
dm_req  in  1  data request, level; held until dm_ready
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data byte address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  read data, valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for DM
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  if_req & ~if_ready
stall_mem  out  1  dm_req & ~dm_ready
conflict_cycles  out  32  saturating count of cycles with if_req=1 and dm_req=1

Behaviour:
- Reset (async, rst=1) forces the following:
  - state=IDLE, all counters 0.
  - mem_en/mem_we/if_ready/dm_ready=0.
  - mem_addr/mem_wdata/if_rdata/dm_rdata=0.
  - An access in flight whose mem_en has not yet pulsed is abandoned and never reaches memory.
- States are IDLE, ACCESS, RESP.
- IDLE:
  - If any request is pending, choose a winner at the clock edge:
    - IF wins if only if_req=1.
    - DM wins if only dm_req=1.
    - If both are pending, DM wins unless starve_cnt >= STARVE_MAX, in which case IF wins.
  - On grant, latch the owner, addr, we (IF always reads), and wdata; load lat_cnt=MEM_LAT; go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_we=latched we only in the first ACCESS cycle (lat_cnt==MEM_LAT).
  - mem_addr and mem_wdata hold the latched values for the whole ACCESS state.
  - lat_cnt decrements each cycle.
  - In the cycle with lat_cnt==1, mem_rdata is valid and is registered into the owner's rdata register (reads only; writes leave rdata unchanged). Then go to RESP.
- RESP:
  - The owner's ready=1 for this single cycle; the other ready stays 0.
  - Next state is IDLE unconditionally.
- Timing:
  - Grant cycle G, mem_en at G+1, ready at G+MEM_LAT+1, IDLE at G+MEM_LAT+2.
  - Peak throughput is one access per MEM_LAT+2 cycles.
- rdata registers hold their last value between accesses.
- starve_cnt:
  - Increments (saturating at 15) on each grant to DM made while if_req=1.
  - Clears on every grant to IF.
- Requesters keep req and their inputs stable until ready. If a requester drops req mid-access, the access still completes and ready still pulses. Inputs are re-sampled only in IDLE.
- stall_if and stall_mem are combinational and go low in the ready cycle, so the stage advances on that edge.
- conflict_cycles increments in any cycle with if_req&dm_req=1, regardless of state, and holds at 0xFFFFFFFF.
- A write to DM and a fetch to the same address are strictly ordered by grant. No merging and no forwarding.

Test Plan:
- IF only, MEM_LAT=2, if_addr=0x00000010 at cycle 0, memory returns 0x20080005:
  - mem_en=1, mem_addr=0x10, mem_we=0 at cycle 1.
  - if_ready=1, if_rdata=0x20080005 at cycle 3.
  - stall_if=1 in cycles 0-2.
- DM write, dm_addr=0x40, dm_wdata=0x000000AA:
  - mem_en=mem_we=1, mem_wdata=0xAA for exactly one cycle.
  - dm_ready at cycle 3.
  - dm_rdata unchanged.
- if_req and dm_req both raised at cycle 0:
  - DM served first (dm_ready at cycle 3).
  - IF granted at cycle 4, if_ready at cycle 7.
  - conflict_cycles=4.
- STARVE_MAX=2, dm_req held continuously (re-raised every access) with if_req=1:
  - Grant order is DM, DM, IF, DM, DM, IF.
- rst pulsed during the grant cycle of a DM write:
  - mem_en never asserts and memory is unchanged.
  - All outputs 0.
  - After rst drops, a new IF request completes in MEM_LAT+2 cycles.
- conflict counter preset near saturation (force 0xFFFFFFFE), both reqs high for 3 cycles:
  - Reads 0xFFFFFFFF and stays there.
